// File: rtl/cmd_dispatch_if.sv
// Command/response handshake between UART_comm and the quadcopter command responder.
// The master side is the UART; the slave side is the dispatcher.
interface cmd_dispatch_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    output cmd_rdy, cmd, data, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd_rdy, cmd, data, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/cmd_dispatch.sv
// Quadcopter command responder: consumes 3-byte remote commands, updates flight
// setpoints, runs the calibration handshake, answers ACK/NACK and guards the link with a watchdog.
module cmd_dispatch #(
  parameter int         WD_WIDTH = 26,
  parameter logic [7:0] ACK      = 8'hA5,
  parameter logic [7:0] NACK     = 8'hEE
) (
  input  logic               clk,
  input  logic               rst_n,
  cmd_dispatch_if.slave      bus,
  output logic               strt_cal,
  input  logic               cal_done,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               motors_off,
  output logic               wd_timeout
);

  localparam logic [7:0] OP_PTCH  = 8'h02;
  localparam logic [7:0] OP_ROLL  = 8'h03;
  localparam logic [7:0] OP_YAW   = 8'h04;
  localparam logic [7:0] OP_THRST = 8'h05;
  localparam logic [7:0] OP_CAL   = 8'h06;
  localparam logic [7:0] OP_LAND  = 8'h07;
  localparam logic [7:0] OP_MOFF  = 8'h08;

  typedef enum logic [1:0] {IDLE, CAL_WAIT, RESP_WAIT} state_t;

  state_t              state, state_nxt;
  logic                accept, cal_ack, resp_sent_q;
  logic [WD_WIDTH-1:0] wd_cnt, wd_inc;
  logic                wd_hit;

  function automatic logic [WD_WIDTH-1:0] sat_inc(input logic [WD_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic known_cmd(input logic [7:0] c);
    return (c >= OP_PTCH) && (c <= OP_MOFF);
  endfunction

  assign wd_inc = sat_inc(wd_cnt);
  // Fires only on the transition into all-ones, not while parked there.
  assign wd_hit = (&wd_inc) && !(&wd_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cal_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_rdy) begin
          accept    = 1'b1;
          state_nxt = (bus.cmd == OP_CAL) ? CAL_WAIT : RESP_WAIT;
        end
      end
      CAL_WAIT: begin
        if (cal_done) begin
          cal_ack   = 1'b1;
          state_nxt = RESP_WAIT;
        end
      end
      RESP_WAIT: begin
        if (bus.resp_sent && !resp_sent_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_sent_q     <= 1'b0;
      bus.clr_cmd_rdy <= 1'b0;
      bus.send_resp   <= 1'b0;
      bus.resp        <= 8'h00;
      strt_cal        <= 1'b0;
      wd_cnt          <= '0;
      wd_timeout      <= 1'b0;
      motors_off      <= 1'b1;
      d_ptch          <= '0;
      d_roll          <= '0;
      d_yaw           <= '0;
      thrst           <= '0;
    end else begin
      resp_sent_q     <= bus.resp_sent;
      bus.clr_cmd_rdy <= accept;
      bus.send_resp   <= (accept && (bus.cmd != OP_CAL)) || cal_ack;
      strt_cal        <= accept && (bus.cmd == OP_CAL);

      if (accept && (bus.cmd != OP_CAL))
        bus.resp <= known_cmd(bus.cmd) ? ACK : NACK;
      else if (cal_ack)
        bus.resp <= ACK;

      if (cal_ack)
        motors_off <= 1'b0;
      else if (accept && (bus.cmd == OP_MOFF))
        motors_off <= 1'b1;

      // An accepted command restarts the link watchdog and wins over a timeout.
      if (accept) begin
        wd_cnt     <= '0;
        wd_timeout <= 1'b0;
        case (bus.cmd)
          OP_PTCH:  d_ptch <= $signed(bus.data);
          OP_ROLL:  d_roll <= $signed(bus.data);
          OP_YAW:   d_yaw  <= $signed(bus.data);
          OP_THRST: thrst  <= bus.data[8:0];
          OP_LAND: begin
            d_ptch <= '0;
            d_roll <= '0;
            d_yaw  <= '0;
            thrst  <= '0;
          end
          default: ;
        endcase
      end else begin
        wd_cnt <= wd_inc;
        if (wd_hit) begin
          wd_timeout <= 1'b1;
          d_ptch     <= '0;
          d_roll     <= '0;
          d_yaw      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch: expected responses are queued when commands
// are issued and matched when send_resp fires; setpoints are tracked by a small model.
module tb_cmd_dispatch;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               strt_cal, cal_done;
  logic signed [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]         thrst;
  logic               motors_off, wd_timeout;

  cmd_dispatch_if bus();

  cmd_dispatch #(.WD_WIDTH(8), .ACK(ACK), .NACK(NACK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .strt_cal   (strt_cal),
    .cal_done   (cal_done),
    .d_ptch     (d_ptch),
    .d_roll     (d_roll),
    .d_yaw      (d_yaw),
    .thrst      (thrst),
    .motors_off (motors_off),
    .wd_timeout (wd_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] exp_q[$];

  logic [15:0] m_ptch, m_roll, m_yaw;
  logic [8:0]  m_thrst;
  logic        m_moff, m_wd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic clr_prev = 1'b0;
  logic send_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.send_resp) begin
      if (exp_q.size() == 0) check("unexpected_send_resp", 16'd1, 16'd0);
      else check("resp_byte", {8'h00, bus.resp}, {8'h00, exp_q.pop_front()});
      check("send_resp_width", {15'd0, send_prev}, 16'd0);
    end
    if (bus.clr_cmd_rdy) check("clr_width", {15'd0, clr_prev}, 16'd0);
    clr_prev  = bus.clr_cmd_rdy;
    send_prev = bus.send_resp;
  end

  task automatic model_reset();
    m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; m_moff = 1'b1; m_wd = 1'b0;
  endtask

  task automatic model_cmd(input logic [7:0] c, input logic [15:0] d);
    m_wd = 1'b0;
    case (c)
      8'h02: m_ptch = d;
      8'h03: m_roll = d;
      8'h04: m_yaw  = d;
      8'h05: m_thrst = d[8:0];
      8'h07: begin m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; end
      8'h08: m_moff = 1'b1;
      default: ;
    endcase
  endtask

  task automatic cmp_state(input string tag);
    check({tag, "_ptch"}, d_ptch, m_ptch);
    check({tag, "_roll"}, d_roll, m_roll);
    check({tag, "_yaw"},  d_yaw,  m_yaw);
    check({tag, "_thrst"}, {7'd0, thrst}, {7'd0, m_thrst});
    check({tag, "_moff"}, {15'd0, motors_off}, {15'd0, m_moff});
    check({tag, "_wd"},   {15'd0, wd_timeout}, {15'd0, m_wd});
  endtask

  task automatic rst_chk(input string tag);
    model_reset();
    cmp_state(tag);
    check({tag, "_resp"}, {8'h00, bus.resp}, 16'h0000);
    check({tag, "_pulses"}, {13'd0, bus.clr_cmd_rdy, bus.send_resp, strt_cal}, 16'd0);
  endtask

  task automatic wait_clr(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.clr_cmd_rdy && n < 500);
    if (!bus.clr_cmd_rdy) check({tag, "_clr_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic finish_cmd(input string tag, input logic [7:0] c, input logic [15:0] d);
    wait_clr(tag);
    bus.cmd_rdy = 1'b0;
    model_cmd(c, d);
    check({tag, "_strt_cal"}, {15'd0, strt_cal}, {15'd0, (c == 8'h06)});
    cmp_state(tag);
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] c, input logic [15:0] d);
    if (c != 8'h06) exp_q.push_back((c >= 8'h02 && c <= 8'h08) ? ACK : NACK);
    @(negedge clk);
    bus.cmd = c; bus.data = d; bus.cmd_rdy = 1'b1;
    finish_cmd(tag, c, d);
  endtask

  task automatic pulse_sent();
    @(negedge clk) bus.resp_sent = 1'b1;
    @(negedge clk) bus.resp_sent = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int cnt, t0, t1;
    rst_n = 1'b0; cal_done = 1'b0;
    bus.cmd_rdy = 1'b0; bus.cmd = 8'h00; bus.data = 16'h0000; bus.resp_sent = 1'b0;
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst_n = 1'b1;

    // Basic pitch command and response hold
    send_cmd("t1", 8'h02, 16'hFF80);
    check("t1_resp", {8'h00, bus.resp}, {8'h00, ACK});
    pulse_sent();
    repeat (3) @(negedge clk);
    check("t1_resp_hold", {8'h00, bus.resp}, {8'h00, ACK});

    // Thrust truncation and emergency land
    send_cmd("t2_thrst", 8'h05, 16'hFFFF);
    pulse_sent();
    send_cmd("t2_yaw", 8'h04, 16'h1234);
    pulse_sent();
    send_cmd("t2_land", 8'h07, 16'hBEEF);
    pulse_sent();

    // Calibration handshake
    send_cmd("t3_cal", 8'h06, 16'h0000);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.send_resp) cnt++;
    end
    check("t3_quiet", cnt[15:0], 16'd0);
    exp_q.push_back(ACK);
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    m_moff = 1'b0;
    check("t3_send_resp", {15'd0, bus.send_resp}, 16'd1);
    check("t3_resp", {8'h00, bus.resp}, {8'h00, ACK});
    cmp_state("t3_ack");
    pulse_sent();
    send_cmd("t3_moff", 8'h08, 16'h0000);
    pulse_sent();

    // Unknown command, then cmd_rdy raised while waiting for resp_sent
    send_cmd("t4_nack", 8'h55, 16'h7777);
    exp_q.push_back(ACK);
    @(negedge clk);
    bus.cmd = 8'h02; bus.data = 16'h1234; bus.cmd_rdy = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.clr_cmd_rdy) cnt++;
    end
    check("t4_not_consumed", cnt[15:0], 16'd0);
    check("t4_ptch_unchanged", d_ptch, m_ptch);
    bus.resp_sent = 1'b1;
    finish_cmd("t4_late", 8'h02, 16'h1234);
    bus.resp_sent = 1'b0;
    pulse_sent();

    // Watchdog timeout
    send_cmd("t5_thrst", 8'h05, 16'h0080);
    pulse_sent();
    send_cmd("t5_roll", 8'h03, 16'h0100);
    t0 = cyc;
    pulse_sent();
    cnt = 0;
    while (!wd_timeout && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    t1 = cyc;
    check("t5_wd_latency", 16'(t1 - t0), 16'd255);
    m_wd = 1'b1; m_ptch = 0; m_roll = 0; m_yaw = 0;
    cmp_state("t5_timeout");
    repeat (20) @(negedge clk);
    cmp_state("t5_saturated");
    send_cmd("t5_clear", 8'h02, 16'h0011);
    pulse_sent();

    // Reset while waiting for calibration
    send_cmd("t6_cal", 8'h06, 16'h0000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_chk("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cal_done = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.send_resp) cnt++;
    end
    cal_done = 1'b0;
    check("t6_no_send", cnt[15:0], 16'd0);
    rst_chk("t6_after");
    send_cmd("t6_idle", 8'h04, 16'hABCD);
    pulse_sent();

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
